// File: rtl/uart_rx_upgraded.sv
// uart_rx_upgraded: 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined) with a fixed BAUD_DIV clocks-per-bit divider
// Ports: clk; reset (async, active-low); rx (serial in, idles high);
//        data_out (last good byte); data_valid (1-cycle pulse when data_out updates);
//        busy (frame in progress); frame_err / parity_err (1-cycle error pulses).
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx_upgraded #(
  parameter int BAUD_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err
);
  localparam int HALF = BAUD_DIV / 2;
  localparam int CW = $clog2(BAUD_DIV);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam state_t AFTER_DATA = PARITY;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state_q, state_d;
  logic meta_q, rx_s_q, rx_d_q;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d, data_out_q, data_out_d;
  logic data_valid_q, data_valid_d, frame_err_q, frame_err_d;
  logic tick, half_tick, stop_samp, par_bad;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, parity_err_q, parity_err_d;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      meta_q       <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_d_q       <= 1'b1;
      state_q      <= IDLE;
      baud_cnt_q   <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      meta_q       <= rx;
      rx_s_q       <= meta_q;
      rx_d_q       <= rx_s_q;
      state_q      <= state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  assign tick      = baud_cnt_q == CW'(BAUD_DIV - 1);
  assign half_tick = baud_cnt_q == CW'(HALF - 1);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rx_d_q && !rx_s_q) state_d = START;
      START:   if (half_tick) state_d = rx_s_q ? IDLE : DATA;
      DATA:    if (tick && bit_idx_q == 3'd7) state_d = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
      PARITY:  if (tick) state_d = STOP;
`endif
      STOP:    if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    // Counter restarts on every state change so each phase is timed from its own entry.
    baud_cnt_d = (state_q == IDLE || state_d != state_q || tick) ? '0 : baud_cnt_q + 1'b1;
    bit_idx_d  = state_q != DATA ? '0 : bit_idx_q + 3'(tick);
    shift_d    = shift_q;
    if (state_q == DATA && tick) shift_d[bit_idx_q] = rx_s_q;
    stop_samp  = state_q == STOP && tick;
`ifdef UART_RX_PARITY_EN
    par_d        = (state_q == PARITY && tick) ? rx_s_q : par_q;
    par_bad      = (^shift_q) != par_q;
    parity_err_d = stop_samp && par_bad;
`else
    par_bad      = 1'b0;
`endif
    data_valid_d = stop_samp && rx_s_q && !par_bad;
    frame_err_d  = stop_samp && !rx_s_q;
    data_out_d   = data_valid_d ? shift_q : data_out_q;
  end
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_upgraded.sv
// tb_uart_rx_upgraded: directed and random frames against a frame-level receiver model
module tb_uart_rx_upgraded;
  localparam int BD = 4;
  localparam int HALF = BD / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FR = HALF + (9 + PB) * BD;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;
  logic [7:0] data_out;
  logic data_valid, busy, frame_err, parity_err;
  int checks = 0;
  int errors = 0;
  int obs_q[$];
  int exp_q[$];
  int run = 0;
  int last_run = 0;
  int busy_at_pulse = 0;
  logic [7:0] exp_dout = 8'h00;
  always #5 clk = ~clk;
  uart_rx_upgraded #(.BAUD_DIV(BD)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data_out(data_out), .data_valid(data_valid),
    .busy(busy), .frame_err(frame_err), .parity_err(parity_err)
  );
  // Record every result pulse as {valid, frame_err, parity_err, data_out} and busy run lengths.
  always @(negedge clk) begin
    if (data_valid === 1'b1 || frame_err === 1'b1 || parity_err === 1'b1) begin
      obs_q.push_back({21'd0, data_valid, frame_err, parity_err, data_out});
      if (busy === 1'b1) busy_at_pulse++;
    end
    if (busy === 1'b1) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v);
    rx = v;
    repeat (BD) @(negedge clk);
  endtask
  // Frame-level model: a byte is delivered only if stop is 1 and parity (when present) matches.
  task automatic send(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    bit good, perr;
    drive(1'b0);
    for (int i = 0; i < 8; i++) drive(b[i]);
    if (PB != 0) drive((^b) ^ !par_ok);
    drive(stop_ok);
    good = stop_ok && (par_ok || PB == 0);
    perr = PB != 0 && !par_ok;
    if (good) exp_dout = b;
    exp_q.push_back({21'd0, good, !stop_ok, perr, exp_dout});
  endtask
  task automatic check_events(input string tag);
    repeat (2 * BD) @(negedge clk);
    chk({tag, " event count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s event %0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " data_out"}, data_out, 0);
    chk({tag, " data_valid"}, data_valid, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " frame_err"}, frame_err, 0);
    chk({tag, " parity_err"}, parity_err, 0);
  endtask
  initial begin
    bit prev_ok, s_ok, p_ok;
    int gap;
    logic [7:0] b;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    reset = 1'b1;
    repeat (2) drive(1'b1);
    obs_q.delete();
    // good frame
    send(8'hA5, 1'b1, 1'b1);
    check_events("good A5");
    chk("good A5 data_out", data_out, 8'hA5);
    chk("good A5 busy width", int'(last_run == FR || last_run == FR + 1), 1);
    // back-to-back
    send(8'h00, 1'b1, 1'b1);
    send(8'hFF, 1'b1, 1'b1);
    check_events("b2b");
    chk("b2b data_out", data_out, 8'hFF);
    // glitch
    last_run = 0;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (3) drive(1'b1);
    check_events("glitch");
    chk("glitch busy width", int'(last_run >= 1 && last_run <= HALF), 1);
    // framing error followed by a break
    send(8'h3C, 1'b0, 1'b1);
    rx = 1'b0;
    repeat (20 * BD) @(negedge clk);
    check_events("frame err + break");
    chk("frame err data_out kept", data_out, 8'hFF);
    drive(1'b1);
    send(8'h5A, 1'b1, 1'b1);
    check_events("after break");
    chk("after break data_out", data_out, 8'h5A);
    // reset in the middle of data bit 3
    b = 8'h81;
    drive(1'b0);
    for (int i = 0; i < 3; i++) drive(b[i]);
    rx = b[3];
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset("mid-frame reset");
    exp_dout = 8'h00;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    reset = 1'b1;
    repeat (2) drive(1'b1);
    obs_q.delete();
    send(8'h81, 1'b1, 1'b1);
    check_events("after reset");
    chk("after reset data_out", data_out, 8'h81);
`ifdef UART_RX_PARITY_EN
    send(8'hA5, 1'b1, 1'b1);
    send(8'hA5, 1'b1, 1'b0);
    check_events("parity");
    chk("parity data_out", data_out, 8'hA5);
`endif
    // random frames, some back-to-back, some with stop or parity errors
    prev_ok = 1'b1;
    for (int n = 0; n < 16; n++) begin
      gap = $urandom_range(0, 2);
      if (!prev_ok && gap == 0) gap = 1;
      repeat (gap) drive(1'b1);
      b = 8'($urandom);
      s_ok = $urandom_range(0, 3) != 0;
      p_ok = $urandom_range(0, 3) != 0;
      send(b, s_ok, p_ok);
      prev_ok = s_ok;
    end
    check_events("random");
    chk("random data_out", data_out, exp_dout);
    chk("pulses while busy", busy_at_pulse, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
